// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan encoder/capture pair.
// Holds the active-low cathode patterns for BCD 0..9 (bits 6:0 = g..a),
// the digit code written for an undecodable pattern, and the capture FSM
// state type.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational cathode-to-BCD decoder.
// Ports:
//   seg   in  7  active-low segments g..a (decimal point excluded)
//   valid out 1  seg matches one of the ten digit patterns
//   digit out 4  decoded BCD digit, DIGIT_INVALID when not valid
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = DIGIT_INVALID;
    case (seg)
      SEG_PAT_0: digit = 4'd0;
      SEG_PAT_1: digit = 4'd1;
      SEG_PAT_2: digit = 4'd2;
      SEG_PAT_3: digit = 4'd3;
      SEG_PAT_4: digit = 4'd4;
      SEG_PAT_5: digit = 4'd5;
      SEG_PAT_6: digit = 4'd6;
      SEG_PAT_7: digit = 4'd7;
      SEG_PAT_8: digit = 4'd8;
      SEG_PAT_9: digit = 4'd9;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed seven-segment bus. Samples the active-low
// anode/cathode lines, waits for each scan dwell to settle, decodes the
// cathode pattern and assembles a frame of NUM_DIGITS digits.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   anode        active-low digit enables (one low bit = valid slot)
//   cathode      active-low segments, bit 7 = dp, bits 6:0 = g..a
//   digits       captured BCD, slot i at [4i+3:4i]
//   digit_err    slot held an undecodable pattern at its last commit
//   dp           captured decimal points (1 = lit)
//   frame_valid  one-cycle pulse once every slot has committed
//   frame_err    OR of digit_err for the completed frame, held to next pulse
// Build option: define SEG7_SCAN_CAPTURE_DP_EN to capture the decimal point;
// otherwise dp is tied to 0 and cathode[7] is ignored.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [7:0]              cathode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_valid,
  output logic                    frame_err
);

`ifdef SEG7_SCAN_CAPTURE_DP_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
  logic unused_dp;
  assign unused_dp = cathode[7];
`endif
  localparam int         SW      = NUM_DIGITS + CW;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [SW-1:0]              sync1, sync2;
  logic [7:0]                 cnt;
  logic                       stable;
  logic                       onehot;
  logic [NUM_DIGITS-1:0]      s2_sel;
  cap_state_e                 state, state_nx;
  logic                       commit;
  logic [NUM_DIGITS-1:0]      cap_sel;
  logic [CW-1:0]              cap_cath;
  logic [NUM_DIGITS-1:0]      wr;
  logic                       dec_valid;
  logic [3:0]                 dec_digit;
  logic [NUM_DIGITS-1:0][3:0] dig_q;
  logic [NUM_DIGITS-1:0]      derr_q;
  logic [NUM_DIGITS-1:0]      seen_q;
  logic                       seen_full;

  // Two-flop input register; resets to blank so reset never commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {anode, cathode[CW-1:0]};
      sync2 <= sync1;
    end
  end

  // Run length of the current sample, saturating at STABLE_CYCLES.
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (sync1 != sync2)  cnt <= 8'd1;
    else if (cnt < CNT_MAX)   cnt <= cnt + 8'd1;
  end

  assign stable = (cnt == CNT_MAX);
  assign s2_sel = ~sync2[SW-1:CW];
  assign onehot = $onehot(s2_sel);

  always_ff @(posedge clk) begin
    if (reset) state <= SETTLE;
    else       state <= state_nx;
  end

  // COMMIT also watches the counter so a change arriving during the commit
  // cycle still re-arms SETTLE for the next dwell.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      SETTLE: if (stable) state_nx = onehot ? COMMIT : HOLD;
      COMMIT: begin
        commit   = 1'b1;
        state_nx = stable ? HOLD : SETTLE;
      end
      HOLD:   if (!stable) state_nx = SETTLE;
      default: state_nx = SETTLE;
    endcase
  end

  // Freeze the settled sample when leaving SETTLE: the sync stage may
  // already carry the next pattern by the time COMMIT executes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_sel  <= '0;
      cap_cath <= '1;
    end else if (state == SETTLE && stable && onehot) begin
      cap_sel  <= s2_sel;
      cap_cath <= sync2[CW-1:0];
    end
  end

  assign wr = commit ? cap_sel : '0;

  seg7_pattern_decode u_dec (
    .seg   (cap_cath[6:0]),
    .valid (dec_valid),
    .digit (dec_digit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q  <= '0;
      derr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr[i]) begin
          dig_q[i]  <= dec_digit;
          derr_q[i] <= ~dec_valid;
        end
      end
    end
  end

  // A commit landing on the clearing cycle seeds the next frame's mask.
  assign seen_full = &seen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= seen_full;
      if (seen_full) begin
        frame_err <= |derr_q;
        seen_q    <= wr;
      end else begin
        seen_q    <= seen_q | wr;
      end
    end
  end

  assign digits    = dig_q;
  assign digit_err = derr_q;

`ifdef SEG7_SCAN_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] dp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr[i]) dp_q[i] <= ~cap_cath[CW-1];
    end
  end

  assign dp = dp_q;
`else
  assign dp = '0;
`endif

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Capture block for the multiplexed 8-digit seven-segment bus: samples the active-low anode and cathode lines, waits for each scan slot to settle, decodes the cathode pattern back to a BCD digit, and assembles a full frame of digits. It is the receive end of the BCD-to-cathode encoding. It is used for display loopback checking and board self-test, and sits between the display pins and the status/debug logic.

## Interface
- NUM_DIGITS, 8, number of anode scan slots (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a commit (2..255)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- anode  in  NUM_DIGITS  active-low digit enables; a valid slot has exactly one bit low
- cathode  in  8  active-low segments; bit 7 = dp, bits 6:0 = g..a
- digits  out  4*NUM_DIGITS  captured BCD, slot i at [4i+3:4i]
- digit_err  out  NUM_DIGITS  slot i held an undecodable pattern at last commit
- dp  out  NUM_DIGITS  captured decimal point (1 = lit)
- frame_valid  out  1  one-cycle pulse when every slot has committed since the last pulse
- frame_err  out  1  OR of digit_err for the completed frame; valid with frame_valid, held until the next pulse

## Operation
- Two-flop input register on {anode, cathode}. Its reset value is all ones (blank), so reset causes no commit.
- Stability counter `cnt`: if the sync output equals the previous sample, `cnt` increments and saturates at STABLE_CYCLES. Otherwise `cnt` loads 1.
- FSM states:
  - SETTLE: waiting for cnt == STABLE_CYCLES.
    - One-hot-low anode: go to COMMIT.
    - Blank (all high) or multi-low anode: go to HOLD with no write.
  - COMMIT: one cycle.
    - Write slot[k] (k = index of the low anode bit).
    - Set seen[k].
    - Go to HOLD.
  - HOLD: stay until the sample changes (cnt reloads 1), then go to SETTLE. Each stable dwell commits exactly once.
- Decode compares cathode[6:0] only:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - Any other value writes digit 4'hF and sets digit_err[k]. A valid decode clears digit_err[k].
- Frame completion:
  - When seen becomes all ones, frame_valid pulses on the next cycle, frame_err is latched, and seen clears.
  - A COMMIT in the same cycle as the clear leaves only that slot's bit set in the new mask.
- A re-commit to an already-seen slot overwrites its value and does not advance the frame.
- Slots with index ≥ NUM_DIGITS do not exist. A low anode bit outside range is treated as multi-low (no write).

## Timing
- All outputs are registered.
- Reset values: digits = 0, digit_err = 0, dp = 0, frame_valid = 0, frame_err = 0, seen = 0, cnt = 0, FSM = SETTLE.
- Latency: a pattern first sampled at edge 0 and held stable updates digits/digit_err/dp at edge STABLE_CYCLES+2.
- The frame_valid pulse occurs one edge after the completing commit.
- A pattern change within STABLE_CYCLES-1 samples (ghosting during scan transitions) produces no commit.
- Reset asserted mid-dwell or mid-frame discards partial state. Capture restarts from SETTLE with seen = 0, and the first post-reset commit takes STABLE_CYCLES+2 edges after reset deasserts.

## Configuration
- SEG7_SCAN_CAPTURE_DP_EN:
  - Defined: cathode[7] is captured into dp[k] at commit (low = lit), and dp=lit does not affect decode.
  - Undefined: the dp output is constant 0, cathode[7] is ignored, and no dp registers exist.

## Structure
- Shared package `seg7_pkg`:
  - The ten cathode pattern constants, shared with the encoder.
  - The DIGIT_INVALID = 4'hF constant.
  - The FSM state typedef (SETTLE/COMMIT/HOLD).
- One sub-module, `seg7_pattern_decode`: combinational cathode[6:0] → {valid, digit[3:0]}. It is reused by self-test logic.

## Test plan
- **Normal frame:** drive slot 0..7 with digits 0..7, held 10 cycles each, STABLE_CYCLES=4 → digits = 0x76543210, frame_valid pulses once, frame_err = 0.
- **Invalid pattern:** slot 3 cathode = 0x7F (blank), rest valid → slot 3 = F, digit_err = 8'h08, frame_err = 1 with frame_valid.
- **Glitch rejection:** anode toggles to slot 5 for 2 cycles, then back → no write to slot 5, seen[5] = 0.
- **Latency and hold:** pattern 0x12 on slot 2 held 50 cycles → digit 5 appears exactly at edge 6, with a single commit (seen set once, no re-write).
- **Multi-low and blank:** anode = 8'hFC or 8'hFF for 20 cycles → no outputs change; frame never completes.
- **Reset mid-frame:** 4 slots committed, reset for 1 cycle → all outputs 0; completing the remaining 4 slots only yields no frame_valid until all 8 commit.
